alu_decode_pipe: RTL and testbench

Registered, parametrised ALU-select decode stage between the instruction register and the ALU/branch unit.
- Accepts 32-bit RV32IM instructions on a valid/ready handshake and decodes each to an ALU select code plus an illegal flag.
- Buffers decoded results in a DEPTH-entry output FIFO so downstream stalls do not stall decode immediately.
- Adds flush, an optional M-extension enable, and saturating statistics counters.

---
 rtl/alu_decode_pipe.sv | 297 +++++++++++++++++++++++++++++
 tb/tb_alu_decode_pipe.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_decode_pipe.sv
// -----------------------------------------------------------------------------
// alu_decode_pipe
//   Registered ALU-select decode stage between the instruction register and
//   the ALU/branch unit. Each accepted RV32IM instruction is decoded
//   combinationally to an ALU select code plus an illegal flag. The result is
//   written, with the raw instruction word, into a DEPTH-entry output FIFO.
//   The FIFO lets a downstream stall be absorbed for a few cycles before decode
//   has to stall.
//
// Parameters
//   SEL_W    : width of the ALU select code (>= 6); codes are zero-extended.
//   DEPTH    : output FIFO entries (power of 2, >= 2).
//   CNT_W    : width of the saturating statistics counters.
//   ENABLE_M : 1 = mul decodes to 0x0A, 0 = mul is flagged illegal.
//
// Ports
//   clk, rst_n            : clock (rising edge), asynchronous active-low reset.
//   flush                 : drops all FIFO contents and any same-cycle input.
//   in_valid/in_ready     : input handshake. in_ready depends on state only.
//   in_instr              : 32-bit instruction word.
//   out_valid/out_ready   : output handshake on the FIFO head.
//   out_select            : head ALU select code.
//   out_illegal           : head instruction is unrecognised.
//   out_instr             : head instruction word, passed through.
//   fifo_level            : current FIFO occupancy.
//   decode_count          : accepted instructions (saturating).
//   illegal_count         : accepted illegal instructions (saturating).
// -----------------------------------------------------------------------------
module alu_decode_pipe #(
  parameter int SEL_W    = 6,
  parameter int DEPTH    = 2,
  parameter int CNT_W    = 16,
  parameter int ENABLE_M = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_instr,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [SEL_W-1:0]           out_select,
  output logic                       out_illegal,
  output logic [31:0]                out_instr,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic [CNT_W-1:0]           decode_count,
  output logic [CNT_W-1:0]           illegal_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(DEPTH);

  // Major opcodes
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MUL  = 7'b0000001;

  // ---------------------------------------------------------------------------
  // Combinational decode
  // ---------------------------------------------------------------------------
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd;

  assign opcode = in_instr[6:0];
  assign rd     = in_instr[11:7];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];

  logic [5:0]       dec_code;
  logic             dec_illegal;
  logic [SEL_W-1:0] dec_select;

  // Every legal path sets both dec_code and dec_illegal=0. Anything that falls
  // through keeps the default of code 0x00 with the illegal flag set.
  always_comb begin
    dec_code    = 6'h00;
    dec_illegal = 1'b1;
    case (opcode)
      OPC_OP: begin
        if (funct7 == F7_BASE) begin
          dec_illegal = 1'b0;
          case (funct3)
            3'b000:  dec_code = 6'h00; // add
            3'b111:  dec_code = 6'h02; // and
            3'b110:  dec_code = 6'h03; // or
            3'b100:  dec_code = 6'h04; // xor
            3'b010:  dec_code = 6'h05; // slt
            3'b011:  dec_code = 6'h06; // sltu
            3'b101:  dec_code = 6'h08; // srl
            default: dec_code = 6'h09; // sll (f3 001)
          endcase
        end else if (funct7 == F7_ALT) begin
          if (funct3 == 3'b000) begin
            dec_code    = 6'h01; // sub
            dec_illegal = 1'b0;
          end else if (funct3 == 3'b101) begin
            dec_code    = 6'h07; // sra
            dec_illegal = 1'b0;
          end
        end else if (funct7 == F7_MUL && funct3 == 3'b000 && ENABLE_M != 0) begin
          dec_code    = 6'h0A; // mul
          dec_illegal = 1'b0;
        end
      end
      OPC_OP_IMM: begin
        case (funct3)
          3'b000: begin dec_code = 6'h0B; dec_illegal = 1'b0; end // addi
          3'b111: begin dec_code = 6'h0D; dec_illegal = 1'b0; end // andi
          3'b110: begin dec_code = 6'h0E; dec_illegal = 1'b0; end // ori
          3'b100: begin dec_code = 6'h0F; dec_illegal = 1'b0; end // xori
          3'b010: begin dec_code = 6'h10; dec_illegal = 1'b0; end // slti
          3'b011: begin dec_code = 6'h11; dec_illegal = 1'b0; end // sltiu
          3'b101: begin
            if (funct7 == F7_ALT) begin
              dec_code    = 6'h12; // srai
              dec_illegal = 1'b0;
            end else if (funct7 == F7_BASE) begin
              dec_code    = 6'h13; // srli
              dec_illegal = 1'b0;
            end
          end
          default: begin // f3 001
            if (funct7 == F7_BASE) begin
              dec_code    = 6'h14; // slli
              dec_illegal = 1'b0;
            end
          end
        endcase
      end
      OPC_LUI: begin
        dec_code    = 6'h15;
        dec_illegal = 1'b0;
      end
      OPC_AUIPC: begin
        dec_code    = 6'h16;
        dec_illegal = 1'b0;
      end
      OPC_LOAD: begin
        if (funct3 == 3'b010) begin
          dec_code    = 6'h17; // lw only
          dec_illegal = 1'b0;
        end
      end
      OPC_STORE: begin
        if (funct3 == 3'b010) begin
          dec_code    = 6'h18; // sw only
          dec_illegal = 1'b0;
        end
      end
      OPC_JAL: begin
        dec_code    = 6'h19;
        dec_illegal = 1'b0;
      end
      OPC_JALR: begin
        if (funct3 == 3'b000) begin
          // jalr with no link register is a plain indirect jump (jr / ret)
          dec_code    = (rd == 5'd0) ? 6'h1B : 6'h1A;
          dec_illegal = 1'b0;
        end
      end
      OPC_BRANCH: begin
        case (funct3)
          3'b000: begin dec_code = 6'h1C; dec_illegal = 1'b0; end // beq
          3'b001: begin dec_code = 6'h1D; dec_illegal = 1'b0; end // bne
          3'b100: begin dec_code = 6'h1E; dec_illegal = 1'b0; end // blt
          3'b101: begin dec_code = 6'h1F; dec_illegal = 1'b0; end // bge
          3'b110: begin dec_code = 6'h20; dec_illegal = 1'b0; end // bltu
          3'b111: begin dec_code = 6'h21; dec_illegal = 1'b0; end // bgeu
          default: ;                                               // f3 010/011
        endcase
      end
      default: ;
    endcase
  end

  assign dec_select = SEL_W'(dec_code);

  // ---------------------------------------------------------------------------
  // Handshake qualification
  // ---------------------------------------------------------------------------
  logic [LVL_W-1:0] level_q, level_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             push, pop;

  // in_ready comes from the registered level only, so a full FIFO does not
  // accept even when the head is popped in the same cycle.
  assign in_ready  = (level_q < DEPTH_L);
  assign out_valid = (level_q != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  // ---------------------------------------------------------------------------
  // Pointer / level next state
  // ---------------------------------------------------------------------------
  always_comb begin
    level_d  = level_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      // Discard everything: the read side jumps to the write side.
      level_d  = '0;
      rd_ptr_d = wr_ptr_q;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      level_q  <= level_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO storage. Entries are cleared on reset so the head outputs read zero
  // straight out of reset; once empty again they simply show stale data.
  // ---------------------------------------------------------------------------
  logic [SEL_W-1:0] mem_sel_q   [DEPTH];
  logic             mem_ill_q   [DEPTH];
  logic [31:0]      mem_instr_q [DEPTH];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          mem_sel_q[gi]   <= '0;
          mem_ill_q[gi]   <= 1'b0;
          mem_instr_q[gi] <= '0;
        end else if (push && (wr_ptr_q == PTR_W'(gi))) begin
          mem_sel_q[gi]   <= dec_select;
          mem_ill_q[gi]   <= dec_illegal;
          mem_instr_q[gi] <= in_instr;
        end
      end
    end
  endgenerate

  assign out_select  = mem_sel_q[rd_ptr_q];
  assign out_illegal = mem_ill_q[rd_ptr_q];
  assign out_instr   = mem_instr_q[rd_ptr_q];
  assign fifo_level  = level_q;

  // ---------------------------------------------------------------------------
  // Saturating statistics counters (unaffected by flush)
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] dec_cnt_q, dec_cnt_d;
  logic [CNT_W-1:0] ill_cnt_q, ill_cnt_d;

  always_comb begin
    dec_cnt_d = dec_cnt_q;
    ill_cnt_d = ill_cnt_q;
    if (push && (dec_cnt_q != '1)) dec_cnt_d = dec_cnt_q + CNT_W'(1);
    if (push && dec_illegal && (ill_cnt_q != '1)) ill_cnt_d = ill_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_cnt_q <= '0;
      ill_cnt_q <= '0;
    end else begin
      dec_cnt_q <= dec_cnt_d;
      ill_cnt_q <= ill_cnt_d;
    end
  end

  assign decode_count  = dec_cnt_q;
  assign illegal_count = ill_cnt_q;

endmodule

// File: tb/tb_alu_decode_pipe.sv
// -----------------------------------------------------------------------------
// Bench for alu_decode_pipe. Three instances share one stimulus stream:
//   dut    : defaults (ENABLE_M=1, CNT_W=16)
//   dut_nm : ENABLE_M=0 (mul must be illegal)
//   dut_c4 : CNT_W=4   (counters must saturate at 0xF)
// Expected decodes are written out per step and queued when driven. Each
// cycle the bench checks handshake/level/counters and the queue head.
// -----------------------------------------------------------------------------
module tb_alu_decode_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_instr;
  logic        out_ready;

  always #5 clk = ~clk;

  // Outputs: main instance
  logic        in_ready, out_valid, out_illegal;
  logic [5:0]  out_select;
  logic [31:0] out_instr;
  logic [1:0]  fifo_level;
  logic [15:0] decode_count, illegal_count;
  // Outputs: ENABLE_M=0 instance
  logic        nm_in_ready, nm_out_valid, nm_out_illegal;
  logic [5:0]  nm_out_select;
  logic [31:0] nm_out_instr;
  logic [1:0]  nm_fifo_level;
  logic [15:0] nm_decode_count, nm_illegal_count;
  // Outputs: CNT_W=4 instance
  logic        c4_in_ready, c4_out_valid, c4_out_illegal;
  logic [5:0]  c4_out_select;
  logic [31:0] c4_out_instr;
  logic [1:0]  c4_fifo_level;
  logic [3:0]  c4_decode_count, c4_illegal_count;

  alu_decode_pipe #(.SEL_W(6), .DEPTH(2), .CNT_W(16), .ENABLE_M(1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_select(out_select), .out_illegal(out_illegal), .out_instr(out_instr),
    .fifo_level(fifo_level), .decode_count(decode_count), .illegal_count(illegal_count)
  );

  alu_decode_pipe #(.SEL_W(6), .DEPTH(2), .CNT_W(16), .ENABLE_M(0)) dut_nm (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(nm_in_ready), .in_instr(in_instr),
    .out_valid(nm_out_valid), .out_ready(out_ready),
    .out_select(nm_out_select), .out_illegal(nm_out_illegal), .out_instr(nm_out_instr),
    .fifo_level(nm_fifo_level), .decode_count(nm_decode_count), .illegal_count(nm_illegal_count)
  );

  alu_decode_pipe #(.SEL_W(6), .DEPTH(2), .CNT_W(4), .ENABLE_M(1)) dut_c4 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(c4_in_ready), .in_instr(in_instr),
    .out_valid(c4_out_valid), .out_ready(out_ready),
    .out_select(c4_out_select), .out_illegal(c4_out_illegal), .out_instr(c4_out_instr),
    .fifo_level(c4_fifo_level), .decode_count(c4_decode_count), .illegal_count(c4_illegal_count)
  );

  typedef struct {
    logic [31:0] instr;
    logic [5:0]  sel;
    logic        ill;
    logic [5:0]  sel_nm;
    logic        ill_nm;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cnt_dec = 0, cnt_ill = 0, cnt_ill_nm = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present an instruction with its expected decode for both M variants.
  task automatic put(input logic [31:0] i, input logic [5:0] s, input logic il,
                     input logic [5:0] s_nm, input logic il_nm);
    in_instr   = i;
    cur.instr  = i;
    cur.sel    = s;
    cur.ill    = il;
    cur.sel_nm = s_nm;
    cur.ill_nm = il_nm;
  endtask

  task automatic put_same(input logic [31:0] i, input logic [5:0] s, input logic il);
    put(i, s, il, s, il);
  endtask

  function automatic int sat4(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  // One clock cycle: check at the negedge, advance the model, step past posedge.
  task automatic cycle();
    int lvl;
    bit acc, pp;
    exp_t e;
    @(negedge clk);
    lvl = sb.size();
    chk("in_ready",        in_ready,        lvl < 2);
    chk("out_valid",       out_valid,       lvl != 0);
    chk("fifo_level",      fifo_level,      lvl);
    chk("nm_fifo_level",   nm_fifo_level,   lvl);
    chk("c4_in_ready",     c4_in_ready,     lvl < 2);
    chk("decode_count",    decode_count,    cnt_dec);
    chk("illegal_count",   illegal_count,   cnt_ill);
    chk("nm_illegal_count", nm_illegal_count, cnt_ill_nm);
    chk("c4_decode_count", c4_decode_count, sat4(cnt_dec));
    chk("c4_illegal_count", c4_illegal_count, sat4(cnt_ill));
    if (lvl != 0) begin
      e = sb[0];
      chk("out_instr",      out_instr,      e.instr);
      chk("out_select",     out_select,     e.sel);
      chk("out_illegal",    out_illegal,    e.ill);
      chk("nm_out_select",  nm_out_select,  e.sel_nm);
      chk("nm_out_illegal", nm_out_illegal, e.ill_nm);
    end
    acc = in_valid && (lvl < 2) && !flush;
    pp  = (lvl != 0) && out_ready && !flush;
    if (flush) begin
      $display("flush: dropped %0d entries", lvl);
      sb.delete();
    end else begin
      if (pp) begin
        $display("pop  instr=%08h sel=%02h ill=%0b", out_instr, out_select, out_illegal);
        void'(sb.pop_front());
      end
      if (acc) begin
        sb.push_back(cur);
        cnt_dec++;
        if (cur.ill)    cnt_ill++;
        if (cur.ill_nm) cnt_ill_nm++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_instr = '0;
    put_same(32'h0, 6'h00, 1'b1);
    #1;
    // Reset state while held in reset
    chk("rst_out_select",  out_select,  0);
    chk("rst_out_illegal", out_illegal, 0);
    chk("rst_out_instr",   out_instr,   0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cycle();

    // add, one cycle of valid, visible the next cycle
    out_ready = 1'b1; in_valid = 1'b1;
    put_same(32'h00B50533, 6'h00, 1'b0); cycle();
    in_valid = 1'b0; cycle();

    // sub, mul (legal only with ENABLE_M=1)
    in_valid = 1'b1;
    put_same(32'h40B50533, 6'h01, 1'b0); cycle();
    put(32'h02B50533, 6'h0A, 1'b0, 6'h00, 1'b1); cycle();
    in_valid = 1'b0; cycle(); cycle();

    // Fill with the consumer stalled; third input must be held off
    out_ready = 1'b0; in_valid = 1'b1;
    put_same(32'h00B50533, 6'h00, 1'b0); cycle();
    put_same(32'h00B54533, 6'h04, 1'b0); cycle();
    put_same(32'h00B56533, 6'h03, 1'b0); cycle();
    cycle();
    // Release the consumer with input still valid; stream continues in order
    out_ready = 1'b1; cycle(); cycle();
    put_same(32'h00B57533, 6'h02, 1'b0); cycle();
    put_same(32'h40B55533, 6'h07, 1'b0); cycle();
    put_same(32'h00150513, 6'h0B, 1'b0); cycle();
    put_same(32'h40155513, 6'h12, 1'b0); cycle();
    in_valid = 1'b0; cycle(); cycle();

    // Fill then flush with a valid input in the flush cycle
    out_ready = 1'b0; in_valid = 1'b1;
    put_same(32'h00151513, 6'h14, 1'b0); cycle();
    put_same(32'h12345537, 6'h15, 1'b0); cycle();
    flush = 1'b1;
    put_same(32'h00000517, 6'h16, 1'b0); cycle();
    flush = 1'b0; in_valid = 1'b0; cycle();
    out_ready = 1'b1; in_valid = 1'b1; cycle();
    in_valid = 1'b0; cycle(); cycle();

    // Control flow, memory ops and illegal encodings, streamed back to back
    in_valid = 1'b1;
    put_same(32'h00008067, 6'h1B, 1'b0); cycle();
    put_same(32'h000080E7, 6'h1A, 1'b0); cycle();
    put_same(32'h0000A063, 6'h00, 1'b1); cycle();
    put_same(32'h00B50063, 6'h1C, 1'b0); cycle();
    put_same(32'h00B57063, 6'h21, 1'b0); cycle();
    put_same(32'h00052503, 6'h17, 1'b0); cycle();
    put_same(32'h00A52023, 6'h18, 1'b0); cycle();
    put_same(32'h0000006F, 6'h19, 1'b0); cycle();
    put_same(32'h00050503, 6'h00, 1'b1); cycle();
    put_same(32'h04B50533, 6'h00, 1'b1); cycle();
    put_same(32'h00000000, 6'h00, 1'b1); cycle();
    put_same(32'h00B53533, 6'h06, 1'b0); cycle();
    in_valid = 1'b0; cycle(); cycle();

    // Asynchronous reset in the middle of a stalled stream
    out_ready = 1'b0; in_valid = 1'b1;
    put_same(32'h00B51533, 6'h09, 1'b0); cycle();
    put_same(32'h00B55533, 6'h08, 1'b0); cycle();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid",     out_valid,     0);
    chk("mid_rst_fifo_level",    fifo_level,    0);
    chk("mid_rst_out_select",    out_select,    0);
    chk("mid_rst_out_illegal",   out_illegal,   0);
    chk("mid_rst_out_instr",     out_instr,     0);
    chk("mid_rst_decode_count",  decode_count,  0);
    chk("mid_rst_illegal_count", illegal_count, 0);
    chk("mid_rst_c4_decode",     c4_decode_count, 0);
    sb.delete();
    cnt_dec = 0; cnt_ill = 0; cnt_ill_nm = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    cycle();
    out_ready = 1'b1; in_valid = 1'b1;
    put_same(32'h00B52533, 6'h05, 1'b0); cycle();
    in_valid = 1'b0; cycle(); cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
